// File: rtl/fpm_pkg.sv
// Shared definitions for the floating-point multiplier datapath.
package fpm_pkg;

    localparam int unsigned MANT_W = 24;
    localparam int unsigned PROD_W = 48;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StCalc = ST_CALC,
        StDone = ST_DONE
    } mult_state_e;

endpackage

// File: rtl/mant_seq_mult.sv
// Iterative shift-add significand multiplier: one multiplier bit per cycle, full 2*Width product,
// valid/ready handshake on operand and result sides.
module mant_seq_mult
    import fpm_pkg::*;
#(
    parameter int unsigned Width = MANT_W
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [Width-1:0]     a_i,
    input  logic [Width-1:0]     b_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*Width-1:0]   p_o
);

    localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;
    localparam int unsigned AccW = 2 * Width + 1;

    // One shift-add step; the Width+1 bit adder keeps the carry out of the high half.
    function automatic logic [AccW-1:0] mult_step(input logic [AccW-1:0]  acc,
                                                  input logic [Width-1:0] mcand);
        logic [Width:0]   hi;
        logic [Width-1:0] lo;
        logic [Width:0]   sum;
        hi  = acc[2*Width:Width];
        lo  = acc[Width-1:0];
        sum = hi + (lo[0] ? {1'b0, mcand} : {(Width + 1){1'b0}});
        return {1'b0, sum, lo[Width-1:1]};
    endfunction

    mult_state_e         state_q;
    logic [AccW-1:0]     acc_q;
    logic [AccW-1:0]     acc_d;
    logic [Width-1:0]    mcand_q;
    logic [CntW-1:0]     cnt_q;
    logic [2*Width-1:0]  p_q;
    logic                in_ready_q;
    logic                out_valid_q;

    assign acc_d = mult_step(acc_q, mcand_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            mcand_q     <= '0;
            cnt_q       <= '0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        mcand_q    <= a_i;
                        acc_q      <= {{(Width + 1){1'b0}}, b_i};
                        cnt_q      <= '0;
                        state_q    <= StCalc;
                        in_ready_q <= 1'b0;
                    end
                end
                StCalc: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(Width - 1)) begin
                        p_q         <= acc_d[2*Width-1:0];
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    // Unused encoding: drop back to a clean idle.
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign p_o         = p_q;

endmodule

// File: tb/tb_mant_seq_mult.sv
// Bench for mant_seq_mult: cycle-level handshake model plus directed literal checks.
module tb_mant_seq_mult;
    import fpm_pkg::*;

    localparam int W = MANT_W;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic            in_ready;
    logic            out_valid;
    logic [2*W-1:0]  p;

    mant_seq_mult #(.Width(W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .p_o         (p)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: one operation in flight; result appears W edges after accept,
    // retires on the first later edge with out_ready.
    int             cyc = 0;
    bit             m_busy = 0;
    int             m_acc = 0;
    logic [2*W-1:0] m_prod = '0;
    logic [2*W-1:0] m_p = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0;
            m_p    = '0;
            cyc    = 0;
        end else begin
            cyc++;
            if (m_busy) begin
                if (cyc == m_acc + W) m_p = m_prod;
                if (cyc > m_acc + W && out_ready) m_busy = 0;
            end else if (in_valid) begin
                m_busy = 1;
                m_acc  = cyc;
                m_prod = (2*W)'(a) * (2*W)'(b);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model in_ready", 64'(in_ready), 64'(!m_busy));
            check("model out_valid", 64'(out_valid), 64'(m_busy && cyc >= m_acc + W));
            check("model p", 64'(p), 64'(m_p));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair, check latency and the literal product, then retire it.
    task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [2*W-1:0] exp, input string name);
        int n;
        check({name, " in_ready before"}, 64'(in_ready), 64'd1);
        a = va;
        b = vb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        check({name, " latency"}, 64'(n), 64'(W));
        check({name, " p"}, 64'(p), 64'(exp));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, " in_ready after"}, 64'(in_ready), 64'd1);
    endtask

    logic [W-1:0]   va_t [4] = '{24'h123456, 24'hFFFFFF, 24'h000000, 24'h800001};
    logic [W-1:0]   vb_t [4] = '{24'h654321, 24'h000001, 24'hABCDEF, 24'hFFFFFF};
    logic [2*W-1:0] hold_p;

    initial begin
        int n;
        int last_cyc;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset p", 64'(p), 64'd0);
        rst_n = 1'b1;
        step();

        do_op(24'h800000, 24'h800000, 48'h4000_0000_0000, "one_x_one");
        do_op(24'hFFFFFF, 24'hFFFFFF, 48'hFFFF_FE00_0001, "max_x_max");
        do_op(24'hC00000, 24'h800000, 48'h6000_0000_0000, "1p5_x_1");
        do_op(24'h000000, 24'hFFFFFF, 48'h0, "zero_a");
        do_op(24'h000003, 24'h000005, 48'h00000000000F, "small");

        // Backpressure: result holds, a stray in_valid is ignored.
        a = 24'h000002;
        b = 24'h000007;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        hold_p = p;
        check("bp p value", 64'(hold_p), 64'd14);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a = 24'h111111;
                b = 24'h222222;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            check("bp p stable", 64'(p), 64'(hold_p));
            check("bp out_valid", 64'(out_valid), 64'd1);
            check("bp in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp released", 64'(in_ready), 64'd1);

        // Back-to-back with in_valid and out_ready held high.
        in_valid = 1'b1;
        out_ready = 1'b1;
        last_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!in_ready && n < 100) begin
                step();
                n++;
            end
            a = va_t[k];
            b = vb_t[k];
            step();
            n = 0;
            while (!out_valid && n < 100) begin
                step();
                n++;
            end
            check("b2b p", 64'(p), 64'((2*W)'(va_t[k]) * (2*W)'(vb_t[k])));
            if (k > 0) check("b2b interval", 64'(cyc - last_cyc), 64'(W + 2));
            last_cyc = cyc;
        end
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end

        // Reset mid-calculation.
        a = 24'hABCDEF;
        b = 24'h123456;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst p", 64'(p), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        step();
        rst_n = 1'b1;
        step();
        do_op(24'h400000, 24'h000004, 48'h000001000000, "after_rst");

        // Random traffic with gaps; the model checks every cycle.
        for (int i = 0; i < 8000; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            a = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
            b = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (30) step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
